// File: rtl/cpu_pkg.sv
// Shared SC-CPU definitions: address width, fetch increment and branch
// offset scaling used by the program counter.
package cpu_pkg;
  localparam int PC_WIDTH     = 32;
  localparam int PC_INCR      = 4;
  localparam int BRANCH_SHIFT = 2;

  typedef logic [PC_WIDTH-1:0] addr_t;
endpackage

// File: rtl/pc_next_logic.sv
// Next-PC datapath: sequential fetch target or PC-relative branch target.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int WIDTH        = PC_WIDTH,
  parameter int INCR         = PC_INCR,
  parameter int OFFSET_SHIFT = BRANCH_SHIFT
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] branch_offset,
  output logic [WIDTH-1:0] next_pc
);
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] byte_offset;
  logic [WIDTH-1:0] br_pc;

  // Branches are relative to the already-incremented PC; all sums wrap.
  assign seq_pc      = pc + WIDTH'(INCR);
  assign byte_offset = branch_offset << OFFSET_SHIFT;
  assign br_pc       = seq_pc + byte_offset;
  assign next_pc     = PCSrc ? br_pc : seq_pc;
endmodule

// File: rtl/program_counter.sv
// SC-CPU program counter: boot address loaded from initPc on reset, then
// advances by INCR or a scaled PC-relative branch on each enabled cycle.
module program_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH        = PC_WIDTH,
  parameter int INCR         = PC_INCR,
  parameter int OFFSET_SHIFT = BRANCH_SHIFT
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic [WIDTH-1:0] initPc,
  output logic [WIDTH-1:0] pc
);
  logic [WIDTH-1:0] next_pc;

  pc_next_logic #(
    .WIDTH        (WIDTH),
    .INCR         (INCR),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) u_next (
    .pc            (pc),
    .PCSrc         (PCSrc),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  // Reset wins over the write enable; initPc is taken verbatim, unaligned.
  always_ff @(posedge clk) begin
    if (Reset)      pc <= initPc;
    else if (PCWre) pc <= next_pc;
  end
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases plus a random run
// against an arithmetic reference model.
module tb_program_counter;
  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [31:0] initPc = '0;
  logic [31:0] pc;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc = '0;

  program_counter dut (
    .clk           (clk),
    .Reset         (Reset),
    .PCWre         (PCWre),
    .PCSrc         (PCSrc),
    .branch_offset (branch_offset),
    .initPc        (initPc),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  // Reference: next address from the architectural rules, modulo 2^32.
  function automatic logic [31:0] ref_next(logic [31:0] cur, logic r, logic we,
                                           logic src, logic [31:0] off,
                                           logic [31:0] init);
    longint unsigned s;
    if (r) return init;
    if (!we) return cur;
    s = longint'(cur) + 64'd4;
    if (src) s = s + longint'(off) * 64'd4;
    return s[31:0];
  endfunction

  task automatic drive(logic r, logic we, logic src, logic [31:0] off,
                       logic [31:0] init);
    Reset = r; PCWre = we; PCSrc = src; branch_offset = off; initPc = init;
    exp_pc = ref_next(exp_pc, r, we, src, off, init);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'd0, 32'd7);
    total++;
    if (pc !== 32'd7) begin bad++; $display("FAIL reset_load got=%h want=%h", pc, 32'd7); end
    drive(0, 1, 0, 32'd0, 32'd7);
    total++;
    if (pc !== 32'd11) begin bad++; $display("FAIL seq_1 got=%h want=%h", pc, 32'd11); end
    drive(0, 1, 0, 32'd0, 32'd7);
    total++;
    if (pc !== 32'd15) begin bad++; $display("FAIL seq_2 got=%h want=%h", pc, 32'd15); end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 32'd0, 32'h100);
    drive(0, 1, 1, 32'd3, 32'h100);
    total++;
    if (pc !== 32'h110) begin bad++; $display("FAIL branch_fwd got=%h want=%h", pc, 32'h110); end
    drive(1, 0, 0, 32'd0, 32'h100);
    drive(0, 1, 1, 32'hFFFF_FFFF, 32'h100);
    total++;
    if (pc !== 32'h100) begin bad++; $display("FAIL branch_self got=%h want=%h", pc, 32'h100); end
  endtask

  task automatic test_hold();
    drive(1, 0, 0, 32'd0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, i[0], 32'd5, 32'h200);
      total++;
      if (pc !== 32'h200) begin bad++; $display("FAIL hold_%0d got=%h want=%h", i, pc, 32'h200); end
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 32'd0, 32'hFFFF_FFFC);
    drive(0, 1, 0, 32'd0, 32'hFFFF_FFFC);
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h want=%h", pc, 32'h0); end
    drive(1, 0, 0, 32'd0, 32'h10);
    drive(0, 1, 1, 32'hFFFF_FFFB, 32'h10);
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL branch_back got=%h want=%h", pc, 32'h0); end
  endtask

  task automatic test_reset_priority();
    drive(1, 0, 0, 32'd0, 32'h40);
    drive(1, 1, 1, 32'd8, 32'h0040_0000);
    total++;
    if (pc !== 32'h0040_0000) begin bad++; $display("FAIL rst_over_branch got=%h want=%h", pc, 32'h0040_0000); end
    drive(1, 0, 0, 32'd0, 32'h40);
    drive(1, 0, 1, 32'd8, 32'h0040_0000);
    total++;
    if (pc !== 32'h0040_0000) begin bad++; $display("FAIL rst_over_hold got=%h want=%h", pc, 32'h0040_0000); end
    drive(0, 1, 0, 32'd8, 32'h0040_0000);
    total++;
    if (pc !== 32'h0040_0004) begin bad++; $display("FAIL rst_release got=%h want=%h", pc, 32'h0040_0004); end
  endtask

  task automatic test_initpc_change();
    drive(0, 0, 0, 32'd0, 32'h1234);
    total++;
    if (pc !== 32'h0040_0004) begin bad++; $display("FAIL initpc_ignored got=%h want=%h", pc, 32'h0040_0004); end
    drive(1, 0, 0, 32'd0, 32'h1234);
    total++;
    if (pc !== 32'h1234) begin bad++; $display("FAIL initpc_load got=%h want=%h", pc, 32'h1234); end
  endtask

  task automatic test_random();
    logic        r, we, src;
    logic [31:0] off;
    int          errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      we  = ($urandom_range(0, 3) != 0);
      src = $urandom_range(0, 1);
      off = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 64)) - 32'd32);
      drive(r, we, src, off, $urandom);
      total++;
      if (pc !== exp_pc) begin
        bad++;
        if (errs < 10) $display("FAIL random_%0d got=%h want=%h", i, pc, exp_pc);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_hold();
    test_wrap();
    test_reset_priority();
    test_initpc_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
